counter_sweep_ctrl: RTL and testbench

- Control-side initiator for the team's loadable up/down counter: drives `load`, `in` and `up_down`, and reads back `count`.
- On `start`, loads a low limit and sweeps the counter lo→hi→lo for a programmed number of sweeps, then parks it at lo.
- Sits between the system control register bank and the counter; the counter itself stays unchanged.

---
 rtl/counter_sweep_pkg.sv | 40 ++++
 rtl/counter_sweep_ctrl_track_chk.sv | 50 +++++
 rtl/counter_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// counter_sweep_pkg: shared types and constants for the counter sweep controller.
// The optional tracking checker is enabled by defining COUNTER_SWEEP_TRACK_CHECK_EN.
package counter_sweep_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_SWEEP_W = 8;

  // Counter direction encoding on up_down
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    UP     = 3'd2,
    DOWN   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // States in which a run is considered in progress
  function automatic logic state_is_busy(input state_t s);
    logic b;
    case (s)
      LOAD, UP, DOWN: b = 1'b1;
      default:        b = 1'b0;
    endcase
    return b;
  endfunction

  // States in which the counter is held at the low limit by a load
  function automatic logic state_is_park(input state_t s);
    logic p;
    case (s)
      IDLE, LOAD, FINISH: p = 1'b1;
      default:            p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/counter_sweep_ctrl_track_chk.sv
// counter_track_chk: mirrors the counter with an expected-count register and
// raises a sticky error when the observed count diverges during a sweep.
// Only instantiated when COUNTER_SWEEP_TRACK_CHECK_EN is defined.
module counter_track_chk
  import counter_sweep_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_exp,
  input  logic         track,
  input  logic         clr,
  input  logic [W-1:0] lo_q,
  input  logic         up_down,
  input  logic [W-1:0] count_i,
  output logic         err
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] exp_r;

  // Expected count: seeded with lo in LOAD, then follows the registered direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_r <= {W{1'b0}};
    end else if (load_exp) begin
      exp_r <= lo_q;
    end else if (track) begin
      exp_r <= (up_down == DIR_DOWN) ? (exp_r - ONE_W) : (exp_r + ONE_W);
    end else begin
      exp_r <= exp_r;
    end
  end

  // Sticky mismatch flag, cleared when a new run is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (track && (count_i != exp_r)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives a loadable up/down counter through a programmed
// number of lo->hi->lo sweeps, then parks it at lo.
// Define COUNTER_SWEEP_TRACK_CHECK_EN to add the count tracking checker on err.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [W-1:0]       lo_limit,
  input  logic [W-1:0]       hi_limit,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [W-1:0]       count_i,
  output logic               load,
  output logic [W-1:0]       load_val,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               err
);

  localparam logic [W-1:0]       ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [SWEEP_W-1:0] ONE_S = {{(SWEEP_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [W-1:0]       lo_q_r, hi_q_r, lo_s, hi_s;
  logic [SWEEP_W-1:0] sweeps_q_r, sweeps_s, sweep_cnt_s, sweep_inc_s;
  logic               done_s;

  assign sweep_inc_s = sweep_cnt + ONE_S;

  // Next state, latched limits and sweep/done bookkeeping
  always_comb begin
    state_s     = state_r;
    lo_s        = lo_q_r;
    hi_s        = hi_q_r;
    sweeps_s    = sweeps_q_r;
    sweep_cnt_s = sweep_cnt;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (stop) begin
          state_s = IDLE;
        end else if (start) begin
          if ((lo_limit < hi_limit) && (sweeps != {SWEEP_W{1'b0}})) begin
            lo_s        = lo_limit;
            hi_s        = hi_limit;
            sweeps_s    = sweeps;
            sweep_cnt_s = {SWEEP_W{1'b0}};
            state_s     = LOAD;
          end else begin
            sweep_cnt_s = {SWEEP_W{1'b0}};
            done_s      = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (stop) begin
          state_s = IDLE;
        end else begin
          state_s = UP;
        end
      end
      UP: begin
        // Turning one below hi lets the counter reach hi exactly once
        if (stop) begin
          state_s = IDLE;
        end else if (count_i == (hi_q_r - ONE_W)) begin
          state_s = DOWN;
        end else begin
          state_s = UP;
        end
      end
      DOWN: begin
        if (stop) begin
          state_s = IDLE;
        end else if (count_i == (lo_q_r + ONE_W)) begin
          sweep_cnt_s = sweep_inc_s;
          if (sweep_inc_s == sweeps_q_r) begin
            state_s = FINISH;
            done_s  = 1'b1;
          end else begin
            state_s = UP;
          end
        end else begin
          state_s = DOWN;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched arguments and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      lo_q_r     <= {W{1'b0}};
      hi_q_r     <= {W{1'b0}};
      sweeps_q_r <= {SWEEP_W{1'b0}};
      sweep_cnt  <= {SWEEP_W{1'b0}};
      done       <= 1'b0;
      busy       <= 1'b0;
      load       <= 1'b0;
      load_val   <= {W{1'b0}};
      up_down    <= DIR_UP;
    end else begin
      state_r    <= state_s;
      lo_q_r     <= lo_s;
      hi_q_r     <= hi_s;
      sweeps_q_r <= sweeps_s;
      sweep_cnt  <= sweep_cnt_s;
      done       <= done_s;
      busy       <= state_is_busy(state_s);
      load       <= state_is_park(state_s);
      load_val   <= lo_s;
      up_down    <= (state_s == DOWN) ? DIR_DOWN : DIR_UP;
    end
  end

`ifdef COUNTER_SWEEP_TRACK_CHECK_EN
  logic chk_load_s, chk_track_s, chk_clr_s;

  assign chk_load_s  = (state_r == LOAD);
  assign chk_track_s = (state_r == UP) || (state_r == DOWN);
  assign chk_clr_s   = (state_r == IDLE) && (state_s == LOAD);

  counter_track_chk #(.W(W)) u_track_chk (
    .clk      (clk),
    .reset    (reset),
    .load_exp (chk_load_s),
    .track    (chk_track_s),
    .clr      (chk_clr_s),
    .lo_q     (lo_q_r),
    .up_down  (up_down),
    .count_i  (count_i),
    .err      (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl: pairs counter_sweep_ctrl with an 8-bit loadable up/down
// counter. Expected sweep counts and done events are queued as stimulus is issued;
// a negedge monitor pops and compares them. COUNTER_SWEEP_TRACK_CHECK_EN selects
// whether a corrupted count is expected to set err.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [7:0] lo_limit, hi_limit, sweeps;
  logic [7:0] cnt, count_to_dut;
  logic       inj;
  logic       load, up_down, busy, done, err;
  logic [7:0] load_val, sweep_cnt;

  typedef struct packed {
    logic [7:0] sc;
    logic [7:0] cv;
  } done_exp_t;

  logic [7:0] exp_cnt_q[$];
  done_exp_t  done_q[$];
  int         errors = 0;
  int         checks = 0;
  int         done_seen = 0;
  bit         mon_en = 1'b1;
  logic [7:0] mon_e;
  done_exp_t  mon_d;
  logic       exp_err;

  localparam logic [7:0] SEQ1 [12] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4,
                                       8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4};
  localparam logic [7:0] SEQ2 [6]  = '{8'd5, 8'd6, 8'd5, 8'd6, 8'd5, 8'd6};

  always #5 clk = ~clk;

  // Team counter: synchronous load, otherwise counts in the up_down direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= 8'd0;
    else if (load)    cnt <= load_val;
    else if (up_down) cnt <= cnt - 8'd1;
    else              cnt <= cnt + 8'd1;
  end

  assign count_to_dut = inj ? 8'h39 : cnt;

  counter_sweep_ctrl #(.W(8), .SWEEP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .lo_limit  (lo_limit),
    .hi_limit  (hi_limit),
    .sweeps    (sweeps),
    .count_i   (count_to_dut),
    .load      (load),
    .load_val  (load_val),
    .up_down   (up_down),
    .busy      (busy),
    .done      (done),
    .sweep_cnt (sweep_cnt),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every sweep cycle and every done pulse consumes one queued expectation
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy && !load) begin
        if (exp_cnt_q.size() == 0) begin
          chk("count_seq_unexpected", {24'd0, cnt}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_cnt_q.pop_front();
          chk("count_seq", {24'd0, cnt}, {24'd0, mon_e});
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          chk("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_sweep_cnt", {24'd0, sweep_cnt}, {24'd0, mon_d.sc});
          chk("done_count", {24'd0, cnt}, {24'd0, mon_d.cv});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] sw);
    lo_limit = lo;
    hi_limit = hi;
    sweeps   = sw;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_done(input logic [7:0] sc, input logic [7:0] cv);
    done_exp_t d;
    d.sc = sc;
    d.cv = cv;
    done_q.push_back(d);
  endtask

  task automatic wait_done(input int max_cycles);
    int base;
    bit seen;
    base = done_seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done_seen != base) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit found;
`ifdef COUNTER_SWEEP_TRACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1; start = 1'b0; stop = 1'b0; inj = 1'b0;
    lo_limit = 8'd0; hi_limit = 8'd0; sweeps = 8'd0;
    tick(2);
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_load_val", {24'd0, load_val}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sweep_cnt", {24'd0, sweep_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick(3);

    // 1: lo=3 hi=6 two sweeps
    foreach (SEQ1[i]) exp_cnt_q.push_back(SEQ1[i]);
    push_done(8'd2, 8'd3);
    do_start(8'd3, 8'd6, 8'd2);
    wait_done(60);
    tick(1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_park", {24'd0, cnt}, 32'd3);
    chk("t1_sweep_cnt", {24'd0, sweep_cnt}, 32'd2);
    chk("t1_queue_empty", exp_cnt_q.size(), 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);

    // 2: hi = lo+1 alternates lo, hi
    foreach (SEQ2[i]) exp_cnt_q.push_back(SEQ2[i]);
    push_done(8'd3, 8'd5);
    do_start(8'd5, 8'd6, 8'd3);
    wait_done(40);
    tick(1);
    chk("t2_park", {24'd0, cnt}, 32'd5);
    chk("t2_sweep_cnt", {24'd0, sweep_cnt}, 32'd3);
    chk("t2_queue_empty", exp_cnt_q.size(), 32'd0);

    // 3: invalid starts: lo==hi, then sweeps==0
    push_done(8'd0, 8'd5);
    do_start(8'd6, 8'd6, 8'd1);
    chk("t3a_busy", {31'd0, busy}, 32'd0);
    chk("t3a_done", {31'd0, done}, 32'd1);
    tick(2);
    chk("t3a_sweep_cnt", {24'd0, sweep_cnt}, 32'd0);
    chk("t3a_park", {24'd0, cnt}, 32'd5);
    push_done(8'd0, 8'd5);
    do_start(8'd1, 8'd4, 8'd0);
    chk("t3b_busy", {31'd0, busy}, 32'd0);
    chk("t3b_done", {31'd0, done}, 32'd1);
    tick(2);
    chk("t3b_park", {24'd0, cnt}, 32'd5);
    chk("t3_done_q_empty", done_q.size(), 32'd0);

    // 4: stop at count 7 in the second sweep, with an ignored start while busy
    for (int v = 0; v <= 8; v++) exp_cnt_q.push_back(8'(v));
    for (int v = 9; v >= 1; v--) exp_cnt_q.push_back(8'(v));
    for (int v = 0; v <= 7; v++) exp_cnt_q.push_back(8'(v));
    do_start(8'd0, 8'd9, 8'd4);
    tick(3);
    do_start(8'd1, 8'd2, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && (cnt == 8'd7) && (sweep_cnt == 8'd1)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("t4_stop_point_timeout", 32'd0, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_sweep_cnt", {24'd0, sweep_cnt}, 32'd1);
    tick(1);
    chk("t4_park", {24'd0, cnt}, 32'd0);
    chk("t4_queue_empty", exp_cnt_q.size(), 32'd0);

    // 5: async reset mid-DOWN, then a normal short run
    mon_en = 1'b0;
    do_start(8'd2, 8'd8, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && up_down) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("t5_down_timeout", 32'd0, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_up_down", {31'd0, up_down}, 32'd0);
    chk("t5_rst_load", {31'd0, load}, 32'd0);
    chk("t5_rst_load_val", {24'd0, load_val}, 32'd0);
    chk("t5_rst_sweep_cnt", {24'd0, sweep_cnt}, 32'd0);
    chk("t5_rst_count", {24'd0, cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    mon_en = 1'b1;
    exp_cnt_q.push_back(8'd1); exp_cnt_q.push_back(8'd2);
    exp_cnt_q.push_back(8'd3); exp_cnt_q.push_back(8'd2);
    push_done(8'd1, 8'd1);
    do_start(8'd1, 8'd3, 8'd1);
    wait_done(30);
    tick(1);
    chk("t5_park", {24'd0, cnt}, 32'd1);
    chk("t5_queue_empty", exp_cnt_q.size(), 32'd0);

    // 6: corrupt count_i for one UP cycle
    for (int v = 10; v <= 19; v++) exp_cnt_q.push_back(8'(v));
    for (int v = 20; v >= 11; v--) exp_cnt_q.push_back(8'(v));
    push_done(8'd1, 8'd10);
    do_start(8'd10, 8'd20, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && (cnt == 8'd12)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("t6_inject_timeout", 32'd0, 32'd1);
    chk("t6_err_before", {31'd0, err}, 32'd0);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("t6_err_set", {31'd0, err}, {31'd0, exp_err});
    wait_done(60);
    tick(1);
    chk("t6_err_sticky", {31'd0, err}, {31'd0, exp_err});
    exp_cnt_q.push_back(8'd1); exp_cnt_q.push_back(8'd2);
    push_done(8'd1, 8'd1);
    do_start(8'd1, 8'd2, 8'd1);
    chk("t6_err_cleared", {31'd0, err}, 32'd0);
    wait_done(20);
    tick(1);
    chk("t6_queue_empty", exp_cnt_q.size(), 32'd0);
    chk("t6_done_q_empty", done_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
